// File: rtl/div_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl_if
// Issue-side and writeback-side handshake bundle for div_issue_ctrl.
//   in_valid/in_ready   : op handshake from the issue stage
//   in_funct3           : RV32M funct3 (1xx = divide family)
//   in_rs1/in_rs2/in_rd : dividend, divisor, destination register
//   out_valid/out_ready : result handshake towards writeback
//   out_data/out_rd     : result value and its destination register
// Modport slave is taken by the divider front end, master by its environment.
// -----------------------------------------------------------------------------
interface div_issue_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [4:0]      in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [4:0]      out_rd;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_rd, out_ready,
        input  in_ready, out_valid, out_data, out_rd
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_rd, out_ready,
        output in_ready, out_valid, out_data, out_rd
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
// Execute-stage front end for RV32M DIV/DIVU/REM/REMU. Decodes signedness,
// resolves divide-by-zero and signed overflow locally, sends magnitudes to an
// iterative divider core with a fixed latency (no done flag), applies the sign
// fix-up, selects quotient or remainder and holds the result for writeback.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   io (slave)   : issue handshake (in_*) and writeback handshake (out_*)
//   flush        : kill the in-flight op (no effect while idle)
//   core_start   : one-cycle start pulse to the divider core
//   core_a/b     : dividend/divisor magnitudes, stable while the core works
//   core_q/r     : core quotient/remainder magnitudes
//   busy         : high whenever an op is in flight; stalls the pipeline
//
// Optional macro DIV_RESULT_CACHE_EN: remember the last core-computed result so
// a repeated rs1/rs2/signedness (DIV followed by REM) skips the core.
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int XLEN         = 32,
    parameter int CORE_LATENCY = 32,
    parameter int CNT_W        = 6
) (
    input  logic            clk,
    input  logic            rst,
    div_issue_ctrl_if.slave io,
    input  logic            flush,
    output logic            core_start,
    output logic [XLEN-1:0] core_a,
    output logic [XLEN-1:0] core_b,
    input  logic [XLEN-1:0] core_q,
    input  logic [XLEN-1:0] core_r,
    output logic            busy
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_SPECIAL = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LATENCY);

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rem_q, rem_d;
    logic             neg1_q, neg1_d;
    logic             neg2_q, neg2_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;

    logic            accept, in_sgn, in_neg1, in_neg2;
    logic            div_zero, ovf, special, capture;
    logic [XLEN-1:0] spec_res, fix_q, fix_r;
    logic            cache_hit;
    logic [XLEN-1:0] hit_res;

    assign accept   = io.in_valid && (state_q == ST_IDLE) && io.in_funct3[2];
    assign in_sgn   = ~io.in_funct3[0];
    assign in_neg1  = in_sgn & io.in_rs1[XLEN-1];
    assign in_neg2  = in_sgn & io.in_rs2[XLEN-1];
    assign div_zero = (io.in_rs2 == '0);
    assign ovf      = in_sgn && (io.in_rs1 == INT_MIN) && (io.in_rs2 == '1);
    assign special  = div_zero | ovf;

    // Div-by-zero: q = all ones, r = dividend. Overflow: q = INT_MIN, r = 0.
    always_comb begin
        spec_res = '0;
        if (io.in_funct3[1]) spec_res = div_zero ? io.in_rs1 : '0;
        else                 spec_res = div_zero ? '1 : INT_MIN;
    end

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    assign fix_q   = neg_if(core_q, neg1_q ^ neg2_q);
    assign fix_r   = neg_if(core_r, neg1_q);
    assign capture = (state_q == ST_RUN) && !flush && (cnt_q == CNT_LAST);

`ifdef DIV_RESULT_CACHE_EN
    logic [XLEN-1:0] pend_rs1_q, pend_rs1_d, pend_rs2_q, pend_rs2_d;
    logic            pend_sgn_q, pend_sgn_d;
    logic            cache_vld_q, cache_vld_d;
    logic [XLEN-1:0] cache_rs1_q, cache_rs1_d, cache_rs2_q, cache_rs2_d;
    logic            cache_sgn_q, cache_sgn_d;
    logic [XLEN-1:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;

    assign cache_hit = cache_vld_q && (io.in_rs1 == cache_rs1_q) &&
                       (io.in_rs2 == cache_rs2_q) && (in_sgn == cache_sgn_q);
    assign hit_res   = io.in_funct3[1] ? cache_rem_q : cache_quo_q;

    always_comb begin
        pend_rs1_d  = pend_rs1_q;
        pend_rs2_d  = pend_rs2_q;
        pend_sgn_d  = pend_sgn_q;
        cache_vld_d = cache_vld_q;
        cache_rs1_d = cache_rs1_q;
        cache_rs2_d = cache_rs2_q;
        cache_sgn_d = cache_sgn_q;
        cache_quo_d = cache_quo_q;
        cache_rem_d = cache_rem_q;
        if (accept && !special && !cache_hit) begin
            pend_rs1_d = io.in_rs1;
            pend_rs2_d = io.in_rs2;
            pend_sgn_d = in_sgn;
        end
        if (capture) begin
            cache_vld_d = 1'b1;
            cache_rs1_d = pend_rs1_q;
            cache_rs2_d = pend_rs2_q;
            cache_sgn_d = pend_sgn_q;
            cache_quo_d = fix_q;
            cache_rem_d = fix_r;
        end else if ((state_q == ST_RUN) && flush) begin
            cache_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cache_vld_q <= 1'b0;
        else     cache_vld_q <= cache_vld_d;
    end

    always_ff @(posedge clk) begin
        pend_rs1_q  <= pend_rs1_d;
        pend_rs2_q  <= pend_rs2_d;
        pend_sgn_q  <= pend_sgn_d;
        cache_rs1_q <= cache_rs1_d;
        cache_rs2_q <= cache_rs2_d;
        cache_sgn_q <= cache_sgn_d;
        cache_quo_q <= cache_quo_d;
        cache_rem_q <= cache_rem_d;
    end
`else
    assign cache_hit = 1'b0;
    assign hit_res   = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        neg1_d  = neg1_q;
        neg2_d  = neg2_q;
        rd_d    = rd_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rd_d   = io.in_rd;
                    rem_d  = io.in_funct3[1];
                    neg1_d = in_neg1;
                    neg2_d = in_neg2;
                    cnt_d  = '0;
                    if (special) begin
                        res_d   = spec_res;
                        state_d = ST_SPECIAL;
                    end else if (cache_hit) begin
                        // Cached result reuses the one-cycle special path.
                        res_d   = hit_res;
                        state_d = ST_SPECIAL;
                    end else begin
                        a_d     = neg_if(io.in_rs1, in_neg1);
                        b_d     = neg_if(io.in_rs2, in_neg2);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = rem_q ? fix_r : fix_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SPECIAL: state_d = flush ? ST_IDLE : ST_DONE;
            default: begin
                if (flush || io.out_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        neg1_q <= neg1_d;
        neg2_q <= neg2_d;
    end

    // The counter only passes through zero on the first RUN cycle, so the
    // start pulse cannot repeat while the core is working.
    assign core_start   = (state_q == ST_RUN) && (cnt_q == '0);
    assign core_a       = a_q;
    assign core_b       = b_q;
    assign io.in_ready  = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign io.out_valid = (state_q == ST_DONE);
    assign io.out_data  = res_q;
    assign io.out_rd    = rd_q;
endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Execute-stage front end for the RV32M divide instructions (DIV, DIVU, REM, REMU).
- Accepts one op from the issue stage and decodes signedness.
- Special cases (divide-by-zero, signed overflow) are resolved locally in 1 cycle.
- All other ops go to the downstream iterative restoring divider core as unsigned magnitudes. The block waits the core's fixed latency, applies sign fix-up, selects quotient or remainder, and holds the result for writeback.

Parameters:
- XLEN, 32, operand/result width.
- CORE_LATENCY, 32, cycles from the core_start pulse until core_q/core_r are valid. The core has no done flag.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > CORE_LATENCY.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  issue stage presents an op.
- in_ready  out  1  block can accept; high only in IDLE.
- in_funct3  in  3  100=DIV, 101=DIVU, 110=REM, 111=REMU; others are ignored (no accept).
- in_rs1  in  XLEN  dividend.
- in_rs2  in  XLEN  divisor.
- in_rd  in  5  destination register.
- flush  in  1  kill the in-flight op.
- core_start  out  1  one-cycle start pulse to the divider core.
- core_a  out  XLEN  dividend magnitude, held stable from core_start until capture.
- core_b  out  XLEN  divisor magnitude, held stable from core_start until capture.
- core_q  in  XLEN  core quotient magnitude.
- core_r  in  XLEN  core remainder magnitude.
- busy  out  1  high in any state except IDLE; drives the pipeline stall.
- out_valid  out  1  result available.
- out_ready  in  1  writeback consumes the result.
- out_data  out  XLEN  result.
- out_rd  out  5  destination register for the result.

Behaviour:
- Reset: all outputs 0 except in_ready=1; state IDLE; counter 0. Reset mid-operation aborts the op with no out_valid.
- Accept: in_valid & in_ready & funct3[2]==1.
  - Latch funct3, rd, operand signs and magnitudes.
  - Signed ops use the two's-complement magnitude when bit31=1; unsigned ops use the raw value.
- IDLE -> SPECIAL on accept when rs2==0 or (signed & rs1==0x80000000 & rs2==0xFFFFFFFF).
  - Next cycle: DONE with the result below.
  - Div by zero: quotient 0xFFFFFFFF; remainder rs1 unchanged.
  - Overflow: quotient 0x80000000; remainder 0.
- IDLE -> RUN on any other accept.
  - core_start=1 for exactly the first RUN cycle; counter cleared on accept.
  - Counter increments each RUN cycle.
  - When counter==CORE_LATENCY, sample core_q/core_r and go to DONE.
- Sign fix-up (signed ops only):
  - Quotient is negated if sign(rs1)^sign(rs2).
  - Remainder is negated if sign(rs1); remainder takes the dividend's sign.
- Selection: funct3[1]=0 selects the quotient, 1 selects the remainder.
- Latency:
  - Normal: out_valid rises CORE_LATENCY+2 rising edges after the accept edge.
  - Special case: out_valid rises 2 edges after the accept edge.
- DONE:
  - out_valid=1; out_data and out_rd are held stable until out_valid & out_ready, then return to IDLE.
  - in_ready is re-asserted the cycle after the handshake; no same-cycle back-to-back accept.
- flush:
  - In RUN/SPECIAL/DONE, forces IDLE on the next edge, drops out_valid, ignores the core result.
  - Flush in IDLE has no effect; flush beats out_ready when both are high.
- core_start never re-pulses while in RUN; core_a/core_b do not change outside IDLE.

Optional Feature:
- DIV_RESULT_CACHE_EN defined:
  - Keep the last completed non-special op's rs1, rs2, signedness, fixed-up quotient and remainder, plus a valid bit.
  - An accept with identical rs1/rs2/signedness goes IDLE -> DONE in 1 cycle with no core_start; this serves the DIV followed by REM pair.
  - Cache is invalidated by rst and by flush during RUN.
- Not defined: no cache storage; every non-special op runs the core.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2, rd=5, out_ready=1 -> one core_start with core_a=7, core_b=2; out_valid at accept+34; out_data=0xFFFFFFFD, out_rd=5.
- REM -7 % 2 -> 0xFFFFFFFF; REMU 0xFFFFFFF9 % 2 -> 1; DIVU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF, with core_a=0xFFFFFFFF.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Both at accept+2 with no core_start.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0. No core_start.
- flush at RUN cycle 10 -> out_valid never rises, busy=0 next cycle. rst at RUN cycle 20 -> same. A new op afterwards completes correctly.
- out_ready held 0 for 5 cycles in DONE -> out_data stable, in_ready=0. With DIV_RESULT_CACHE_EN: DIV 100/7 then REM 100/7 -> 14, then 2 at accept+2 with no core_start.
